watchdog_bank: RTL and testbench

// Bank of CHANNELS independent watchdog timers sharing one free-running prescaler.

---
 rtl/watchdog_bank_pkg.sv | 42 ++++
 rtl/watchdog_bank_if.sv | 30 +++
 rtl/wdt_prescaler.sv | 24 ++
 rtl/watchdog_bank.sv | 89 ++++++++
 tb/tb_watchdog_bank.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/watchdog_bank_pkg.sv
// Shared definitions for the watchdog bank: channel-index sizing and the
// per-channel action decode used by every timer channel.
package watchdog_bank_pkg;

    localparam int MAX_CHANNELS = 16;

    typedef enum logic [2:0] {
        ACT_DISABLE,
        ACT_KICK,
        ACT_EXPIRE,
        ACT_COUNT,
        ACT_HOLD
    } chan_action_e;

    function automatic int chan_bits(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Disable beats kick, and kick beats a simultaneous tick; an expired
    // channel ignores ticks until it is restarted.
    function automatic chan_action_e chan_action(
        input logic enable,
        input logic kick,
        input logic tick,
        input logic expired,
        input logic at_limit
    );
        chan_action_e action;
        if (!enable)
            action = ACT_DISABLE;
        else if (kick)
            action = ACT_KICK;
        else if (tick && !expired && at_limit)
            action = ACT_EXPIRE;
        else if (tick && !expired)
            action = ACT_COUNT;
        else
            action = ACT_HOLD;
        return action;
    endfunction

endpackage

// File: rtl/watchdog_bank_if.sv
// Control/status bundle between a protocol front-end (master) and the
// watchdog bank (slave).
interface watchdog_bank_if
    import watchdog_bank_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int COUNT_BITS = 8
);
    localparam int CHAN_BITS = chan_bits(CHANNELS);

    logic [CHANNELS-1:0]   enable;
    logic [CHANNELS-1:0]   kick;
    logic                  load_en;
    logic [CHAN_BITS-1:0]  load_chan;
    logic [COUNT_BITS-1:0] load_value;
    logic [CHANNELS-1:0]   expired;
    logic [CHANNELS-1:0]   expire_pulse;
    logic                  any_expired;

    modport master (
        output enable, kick, load_en, load_chan, load_value,
        input  expired, expire_pulse, any_expired
    );

    modport slave (
        input  enable, kick, load_en, load_chan, load_value,
        output expired, expire_pulse, any_expired
    );

endinterface

// File: rtl/wdt_prescaler.sv
// Free-running prescaler; tick is high for the single cycle the counter is
// all-ones, so one tick every 2**PRESCALE_BITS clocks.
module wdt_prescaler #(
    parameter int PRESCALE_BITS = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [PRESCALE_BITS-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = &count;

endmodule

// File: rtl/watchdog_bank.sv
// Bank of independent watchdog timers sharing one prescaler; each channel
// counts prescaler ticks since its last kick and flags expiry past its limit.
module watchdog_bank
    import watchdog_bank_pkg::*;
#(
    parameter int CHANNELS         = 4,
    parameter int PRESCALE_BITS    = 10,
    parameter int COUNT_BITS       = 8,
    parameter bit EXPIRED_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    watchdog_bank_if.slave  bus
);

    localparam int CHAN_BITS = chan_bits(CHANNELS);

    logic                tick;
    logic [CHANNELS-1:0] expired_q;
    logic [CHANNELS-1:0] pulse_q;
    logic                any_q;

    wdt_prescaler #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [COUNT_BITS-1:0] count;
        logic [COUNT_BITS-1:0] limit;
        logic                  exp_r;
        logic                  pulse_r;
        logic                  load_hit;
        chan_action_e          action;

        // Matching against in-range indices only drops writes to absent channels.
        assign load_hit = bus.load_en && (bus.load_chan == CHAN_BITS'(i));

        always_comb begin
            action = chan_action(bus.enable[i], bus.kick[i], tick, exp_r,
                                 count >= limit);
        end

        // NOTE: the limit registers are reset too, so a fresh bank always
        // starts with the longest timeout rather than an undefined one.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count   <= '0;
                limit   <= '1;
                exp_r   <= EXPIRED_ON_RESET;
                pulse_r <= 1'b0;
            end else begin
                pulse_r <= 1'b0;
                if (load_hit)
                    limit <= bus.load_value;
                case (action)
                    ACT_DISABLE, ACT_KICK: begin
                        count <= '0;
                        exp_r <= 1'b0;
                    end
                    ACT_EXPIRE: begin
                        exp_r   <= 1'b1;
                        pulse_r <= 1'b1;
                    end
                    ACT_COUNT: count <= count + 1'b1;
                    default: ;
                endcase
            end
        end

        assign expired_q[i] = exp_r;
        assign pulse_q[i]   = pulse_r;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            any_q <= EXPIRED_ON_RESET;
        else
            any_q <= |expired_q;
    end

    assign bus.expired      = expired_q;
    assign bus.expire_pulse = pulse_q;
    assign bus.any_expired  = any_q;

endmodule

// File: tb/tb_watchdog_bank.sv
// Self-checking bench for watchdog_bank: directed scenarios followed by a
// randomized phase, all compared every cycle against a behavioural model.
module tb_watchdog_bank;

    localparam int CH     = 4;
    localparam int P      = 2;
    localparam int CB     = 4;
    localparam int PERIOD = 1 << P;
    localparam int MAXLIM = (1 << CB) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    watchdog_bank_if #(.CHANNELS(CH), .COUNT_BITS(CB)) bus ();

    watchdog_bank #(
        .CHANNELS        (CH),
        .PRESCALE_BITS   (P),
        .COUNT_BITS      (CB),
        .EXPIRED_ON_RESET(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: clocks since reset, ticks elapsed since each channel's restart,
    // and per-channel limit/expired/pulse.
    int          m_phase;
    int          m_ticks [CH];
    int          m_lim   [CH];
    bit [CH-1:0] m_exp;
    bit [CH-1:0] m_pulse;
    bit          m_any;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0;
        for (int i = 0; i < CH; i++) begin
            m_ticks[i] = 0;
            m_lim[i]   = MAXLIM;
        end
        m_exp   = '1;
        m_pulse = '0;
        m_any   = 1'b1;
    endfunction

    // One clock of the specified behaviour, using the inputs currently driven.
    function automatic void model_step();
        bit tick;
        tick    = (m_phase % PERIOD) == PERIOD - 1;
        m_phase = m_phase + 1;
        m_any   = |m_exp;
        for (int i = 0; i < CH; i++) begin
            m_pulse[i] = 1'b0;
            if (!bus.enable[i] || bus.kick[i]) begin
                m_ticks[i] = 0;
                m_exp[i]   = 1'b0;
            end else if (tick && !m_exp[i]) begin
                if (m_ticks[i] >= m_lim[i]) begin
                    m_exp[i]   = 1'b1;
                    m_pulse[i] = 1'b1;
                end else begin
                    m_ticks[i] = m_ticks[i] + 1;
                end
            end
        end
        if (bus.load_en && int'(bus.load_chan) < CH)
            m_lim[int'(bus.load_chan)] = int'(bus.load_value);
    endfunction

    task automatic compare_all();
        check("expired", 32'(bus.expired), 32'(m_exp));
        check("expire_pulse", 32'(bus.expire_pulse), 32'(m_pulse));
        check("any_expired", 32'(bus.any_expired), 32'(m_any));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic load(input int chan, input int value, input logic [CH-1:0] kicks);
        bus.load_en    = 1'b1;
        bus.load_chan  = 2'(chan);
        bus.load_value = 4'(value);
        bus.kick       = kicks;
        cycle();
        bus.load_en = 1'b0;
        bus.kick    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int  n;
        bit  found;

        bus.enable     = '0;
        bus.kick       = '0;
        bus.load_en    = 1'b0;
        bus.load_chan  = '0;
        bus.load_value = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_expired", 32'(bus.expired), 32'hF);
        check("rst_pulse", 32'(bus.expire_pulse), 32'h0);
        check("rst_any", 32'(bus.any_expired), 32'h1);
        reset      = 1'b0;
        bus.enable = '1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            check("t1_expired_held", 32'(bus.expired), 32'hF);
            check("t1_no_pulse", 32'(bus.expire_pulse), 32'h0);
        end

        // Basic expiry: limit 3 expires 13..16 clocks after the kick
        load(0, 3, 4'b1111);
        n = 0;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            cycle();
            n++;
            found = bus.expired[0];
        end
        check("t2_latency", 32'(found && n >= 13 && n <= 16), 32'h1);
        check("t2_pulse_hi", 32'(bus.expire_pulse[0]), 32'h1);
        check("t2_any_lags", 32'(bus.any_expired), 32'h0);
        cycle();
        check("t2_pulse_lo", 32'(bus.expire_pulse[0]), 32'h0);
        check("t2_any_hi", 32'(bus.any_expired), 32'h1);

        // Regular kicks keep channel 1 alive
        load(1, 2, 4'b0010);
        for (int c = 1; c <= 200; c++) begin
            bus.kick[1] = (c % 8 == 0);
            cycle();
            check("t3_ch1_alive", 32'(bus.expired[1]), 32'h0);
        end
        bus.kick = '0;

        // Kick on the very tick that would expire channel 2
        load(2, 1, 4'b0100);
        found = 0;
        for (int c = 0; c < 12 && !found; c++) begin
            if (m_ticks[2] == 1 && (m_phase % PERIOD) == PERIOD - 1)
                found = 1;
            else
                cycle();
        end
        check("t4_reach_limit", 32'(found), 32'h1);
        bus.kick[2] = 1'b1;
        cycle();
        bus.kick[2] = 1'b0;
        check("t4_no_expiry", 32'(bus.expired[2]), 32'h0);
        check("t4_no_pulse", 32'(bus.expire_pulse[2]), 32'h0);
        repeat (4) cycle();
        check("t4_one_tick", 32'(bus.expired[2]), 32'h0);
        repeat (4) cycle();
        check("t4_two_ticks", 32'(bus.expired[2]), 32'h1);

        // Lowering the limit below the current count expires on the next tick
        load(2, MAXLIM, 4'b0100);
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            cycle();
            found = (m_ticks[2] == 5);
        end
        check("t5_reach_count5", 32'(found), 32'h1);
        load(2, 2, 4'b0000);
        n = 1;
        found = bus.expired[2];
        for (int c = 0; c < 6 && !found; c++) begin
            cycle();
            n++;
            found = bus.expired[2];
        end
        check("t5_lowered_expiry", 32'(found && n <= 5), 32'h1);
        bus.enable[2] = 1'b0;
        cycle();
        check("t5_disable_clears", 32'(bus.expired[2]), 32'h0);
        bus.enable[2] = 1'b1;

        // A value on the load bus without load_en must not change channel 3's limit
        bus.load_chan  = 2'd3;
        bus.load_value = 4'd0;
        bus.kick[3]    = 1'b1;
        cycle();
        bus.kick[3] = 1'b0;
        repeat (5) cycle();
        check("t5_no_load_ch3", 32'(bus.expired[3]), 32'h0);

        // Asynchronous reset mid-count
        bus.kick = '1;
        cycle();
        bus.kick = '0;
        repeat (6) cycle();
        #3;
        reset = 1'b1;
        #1;
        check("t6_rst_expired", 32'(bus.expired), 32'hF);
        check("t6_rst_pulse", 32'(bus.expire_pulse), 32'h0);
        check("t6_rst_any", 32'(bus.any_expired), 32'h1);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        bus.kick = '1;
        cycle();
        bus.kick = '0;
        n = 0;
        found = 0;
        for (int c = 0; c < 80 && !found; c++) begin
            cycle();
            n++;
            found = bus.expired[3];
        end
        check("t6_limit_all_ones", 32'(found && n >= 61 && n <= 64), 32'h1);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 31) == 0)
                    bus.enable[i] = ~bus.enable[i];
                bus.kick[i] = ($urandom_range(0, 15) == 0);
            end
            bus.load_en    = ($urandom_range(0, 7) == 0);
            bus.load_chan  = 2'($urandom_range(0, 3));
            bus.load_value = 4'($urandom_range(0, 5));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
